// File: rtl/exu_mc.sv
// exu_mc: in-order execution unit. Single-cycle ALU/branch ops, plus an iterative
// shift-add multiplier and restoring divider sharing one datapath behind valid/ready.
module exu_mc #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [3:0]      in_alu_op,
    input  logic [3:0]      in_br_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_target,
    output logic            out_redirect
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t state, state_nx;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc, opq, opb;
    logic            is_div, is_rem, neg_q, neg_r;
    logic            accept, busy, finish;

    logic [XLEN-1:0] sc_res, sc_tgt;
    logic            sc_redir, sc_mc;
    logic            div_zero, div_ovf, op_sgn, a_neg, b_neg;

    assign div_zero = (in_b == '0);
    assign div_ovf  = (in_a == SMIN) && (in_b == '1);
    assign op_sgn   = (in_alu_op == 4'd11) || (in_alu_op == 4'd13);
    assign a_neg    = op_sgn && in_a[XLEN-1];
    assign b_neg    = op_sgn && in_b[XLEN-1];

    always_comb begin
        sc_res   = '0;
        sc_tgt   = '0;
        sc_redir = 1'b0;
        sc_mc    = 1'b0;
        if (in_br_sel >= 4'd1 && in_br_sel <= 4'd8) begin
            sc_tgt = in_pc + in_imm;
            case (in_br_sel)
                4'd1: sc_redir = (in_a == in_b);
                4'd2: sc_redir = (in_a != in_b);
                4'd3: sc_redir = $signed(in_a) < $signed(in_b);
                4'd4: sc_redir = $signed(in_a) >= $signed(in_b);
                4'd5: sc_redir = in_a < in_b;
                4'd6: sc_redir = in_a >= in_b;
                default: begin  // JAL / JALR
                    sc_redir = 1'b1;
                    sc_res   = in_pc + XLEN'(4);
                    if (in_br_sel == 4'd8) sc_tgt = (in_a + in_imm) & ~XLEN'(1);
                end
            endcase
        end else begin
            case (in_alu_op)
                4'd0:  sc_res = in_a + in_b;
                4'd1:  sc_res = in_a - in_b;
                4'd2:  sc_res = in_a & in_b;
                4'd3:  sc_res = in_a | in_b;
                4'd4:  sc_res = in_a ^ in_b;
                4'd5:  sc_res = in_a << in_b[SHW-1:0];
                4'd6:  sc_res = in_a >> in_b[SHW-1:0];
                4'd7:  sc_res = $unsigned($signed(in_a) >>> in_b[SHW-1:0]);
                4'd8:  sc_res = XLEN'($signed(in_a) < $signed(in_b));
                4'd9:  sc_res = XLEN'(in_a < in_b);
                4'd10: sc_mc  = 1'b1;
                // divide corner cases resolve here without iterating
                4'd11: if (div_zero) sc_res = '1; else if (div_ovf) sc_res = in_a; else sc_mc = 1'b1;
                4'd12: if (div_zero) sc_res = '1; else sc_mc = 1'b1;
                4'd13: if (div_zero) sc_res = in_a; else if (!div_ovf) sc_mc = 1'b1;
                4'd14: if (div_zero) sc_res = in_a; else sc_mc = 1'b1;
                default: sc_res = '0;
            endcase
        end
    end

    // Iteration 1 runs on the accept edge from the operands, the rest from registers.
    logic            step_div;
    logic [XLEN-1:0] s_acc, s_q, s_b, acc_nx, q_nx, b_nx, mag_a, mag_b, mc_res;
    logic [XLEN:0]   rem_sh, diff;

    assign busy     = (state == BUSY);
    assign mag_a    = a_neg ? -in_a : in_a;
    assign mag_b    = b_neg ? -in_b : in_b;
    assign step_div = busy ? is_div : (in_alu_op != 4'd10);
    assign s_acc    = busy ? acc : '0;
    assign s_q      = busy ? opq : (step_div ? mag_a : in_b);
    assign s_b      = busy ? opb : (step_div ? mag_b : in_a);
    assign rem_sh   = {s_acc, s_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, s_b};

    always_comb begin
        if (step_div) begin
            acc_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            q_nx   = {s_q[XLEN-2:0], ~diff[XLEN]};
            b_nx   = s_b;
        end else begin
            acc_nx = s_acc + (s_q[0] ? s_b : '0);
            q_nx   = s_q >> 1;
            b_nx   = s_b << 1;
        end
        if (!is_div)     mc_res = acc_nx;
        else if (is_rem) mc_res = neg_r ? -acc_nx : acc_nx;
        else             mc_res = neg_q ? -q_nx : q_nx;
    end

    assign in_ready  = !rst && !flush && ((state == IDLE) || (state == HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign finish    = busy && (cnt == CW'(2));  // counter steps to 1 on this edge
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = sc_mc ? BUSY : HOLD;
            BUSY:    if (finish) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = accept ? (sc_mc ? BUSY : HOLD) : IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            opq          <= '0;
            opb          <= '0;
            is_div       <= 1'b0;
            is_rem       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            out_result   <= '0;
            out_target   <= '0;
            out_redirect <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept && !sc_mc) begin
                out_result   <= sc_res;
                out_target   <= sc_tgt;
                out_redirect <= sc_redir;
            end else if (accept || busy) begin
                acc <= acc_nx;
                opq <= q_nx;
                opb <= b_nx;
                cnt <= accept ? CW'(XLEN) : cnt - CW'(1);
                if (accept) begin
                    is_div <= (in_alu_op != 4'd10);
                    is_rem <= (in_alu_op == 4'd13) || (in_alu_op == 4'd14);
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                end
                if (finish) begin
                    out_result   <= mc_res;
                    out_target   <= '0;
                    out_redirect <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_exu_mc.sv
// Bench for exu_mc: directed vector table, hand-built handshake/flush/reset sequences,
// and randomized ops scored against a plain-arithmetic model.
module tb_exu_mc;
    localparam int XLEN = 64;
    typedef logic [XLEN-1:0] word_t;
    localparam word_t MIN = 64'h8000_0000_0000_0000;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready, out_redirect;
    word_t      in_a, in_b, in_pc, in_imm, out_result, out_target;
    logic [3:0] in_alu_op, in_br_sel;
    int         tests = 0, fails = 0;

    exu_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_br_sel(in_br_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_target(out_target), .out_redirect(out_redirect)
    );

    always #5 clk = ~clk;

    typedef struct { word_t res; word_t tgt; logic rd; int lat; } exp_t;
    typedef struct { word_t res; word_t tgt; logic rd; int lat; logic rdy_busy; } obs_t;
    typedef struct {
        logic [3:0] alu; logic [3:0] br;
        word_t a; word_t b; word_t pc; word_t imm;
        exp_t e;
    } vec_t;

    task automatic check(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Reference: the architectural meaning of each code, in plain arithmetic.
    function automatic exp_t model(input logic [3:0] alu, input logic [3:0] br,
                                   input word_t a, input word_t b, input word_t pc, input word_t imm);
        exp_t e;
        logic signed [XLEN-1:0] sa, sb;
        int sh;
        word_t low6;
        sa = a; sb = b; low6 = b & 64'h3F; sh = int'(low6);
        e.res = '0; e.tgt = '0; e.rd = 1'b0; e.lat = 1;
        if (br >= 4'd1 && br <= 4'd8) begin
            e.tgt = pc + imm;
            case (br)
                4'd1: e.rd = (a == b);
                4'd2: e.rd = (a != b);
                4'd3: e.rd = (sa < sb);
                4'd4: e.rd = (sa >= sb);
                4'd5: e.rd = (a < b);
                4'd6: e.rd = (a >= b);
                4'd7: begin e.rd = 1'b1; e.res = pc + 64'd4; end
                default: begin e.rd = 1'b1; e.res = pc + 64'd4; e.tgt = (a + imm) & ~64'd1; end
            endcase
        end else begin
            case (alu)
                4'd0:  e.res = a + b;
                4'd1:  e.res = a - b;
                4'd2:  e.res = a & b;
                4'd3:  e.res = a | b;
                4'd4:  e.res = a ^ b;
                4'd5:  e.res = a << sh;
                4'd6:  e.res = a >> sh;
                4'd7:  e.res = sa >>> sh;
                4'd8:  e.res = (sa < sb) ? 64'd1 : 64'd0;
                4'd9:  e.res = (a < b) ? 64'd1 : 64'd0;
                4'd10: begin e.res = a * b; e.lat = XLEN; end
                4'd11: if (b == 0) e.res = '1; else if (a == MIN && b == '1) e.res = a;
                       else begin e.res = sa / sb; e.lat = XLEN; end
                4'd12: if (b == 0) e.res = '1; else begin e.res = a / b; e.lat = XLEN; end
                4'd13: if (b == 0) e.res = a; else if (a == MIN && b == '1) e.res = '0;
                       else begin e.res = sa % sb; e.lat = XLEN; end
                4'd14: if (b == 0) e.res = a; else begin e.res = a % b; e.lat = XLEN; end
                default: e.res = '0;
            endcase
        end
        return e;
    endfunction

    // Offer one op, wait for its result with out_ready low, then consume it.
    task automatic do_op(input logic [3:0] alu, input logic [3:0] br, input word_t a, input word_t b,
                         input word_t pc, input word_t imm, output obs_t o);
        int n;
        in_alu_op = alu; in_br_sel = br; in_a = a; in_b = b; in_pc = pc; in_imm = imm;
        in_valid = 1'b1; out_ready = 1'b0; o.rdy_busy = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0; o.lat = 1;
        while (!out_valid && o.lat < 200) begin
            if (in_ready) o.rdy_busy = 1'b1;
            @(posedge clk); #1; o.lat++;
        end
        o.res = out_result; o.tgt = out_target; o.rd = out_redirect;
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic run_cmp(input string tag, input logic [3:0] alu, input logic [3:0] br, input word_t a,
                           input word_t b, input word_t pc, input word_t imm, input exp_t e);
        obs_t o;
        do_op(alu, br, a, b, pc, imm, o);
        check($sformatf("%s result", tag), o.res, e.res);
        check($sformatf("%s target", tag), o.tgt, e.tgt);
        check($sformatf("%s redirect", tag), word_t'(o.rd), word_t'(e.rd));
        check($sformatf("%s latency", tag), word_t'(o.lat), word_t'(e.lat));
        if (e.lat > 1) check($sformatf("%s in_ready while busy", tag), word_t'(o.rdy_busy), '0);
    endtask

    function automatic vec_t mk(input logic [3:0] alu, input logic [3:0] br, input word_t a, input word_t b,
                                input word_t pc, input word_t imm, input word_t res, input word_t tgt,
                                input logic rd, input int lat);
        vec_t v;
        v.alu = alu; v.br = br; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
        v.e.res = res; v.e.tgt = tgt; v.e.rd = rd; v.e.lat = lat;
        return v;
    endfunction

    initial begin
        vec_t  vt[$];
        exp_t  e;
        logic  seen;
        logic [3:0] ralu, rbr;
        word_t ra, rb;
        int    sel;

        vt.push_back(mk(4'd0,  4'd0, 64'd5, 64'd7, 0, 0, 64'd12, 0, 1'b0, 1));
        vt.push_back(mk(4'd7,  4'd0, MIN, 64'd4, 0, 0, 64'hF800_0000_0000_0000, 0, 1'b0, 1));
        vt.push_back(mk(4'd9,  4'd0, 64'd1, '1, 0, 0, 64'd1, 0, 1'b0, 1));
        vt.push_back(mk(4'd10, 4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0, 64));
        vt.push_back(mk(4'd11, 4'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0, 64));
        vt.push_back(mk(4'd13, 4'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0, '1, 0, 1'b0, 64));
        vt.push_back(mk(4'd12, 4'd0, 64'd9, 64'd0, 0, 0, '1, 0, 1'b0, 1));
        vt.push_back(mk(4'd13, 4'd0, 64'd9, 64'd0, 0, 0, 64'd9, 0, 1'b0, 1));
        vt.push_back(mk(4'd11, 4'd0, MIN, '1, 0, 0, MIN, 0, 1'b0, 1));
        vt.push_back(mk(4'd13, 4'd0, MIN, '1, 0, 0, 64'd0, 0, 1'b0, 1));
        vt.push_back(mk(4'd10, 4'd3, '1, 64'd1, 64'h100, 64'h20, 64'd0, 64'h120, 1'b1, 1));
        vt.push_back(mk(4'd0,  4'd8, 64'h201, 64'd0, 64'h400, 64'd0, 64'h404, 64'h200, 1'b1, 1));
        vt.push_back(mk(4'd0,  4'd1, 64'd1, 64'd2, 64'h100, 64'h20, 64'd0, 64'h120, 1'b0, 1));
        vt.push_back(mk(4'd1,  4'd0, 64'd5, 64'd7, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0, 1));
        vt.push_back(mk(4'd15, 4'd0, 64'd5, 64'd7, 0, 0, 64'd0, 0, 1'b0, 1));
        vt.push_back(mk(4'd0,  4'd7, 0, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1004, 64'hFF8, 1'b1, 1));
        vt.push_back(mk(4'd12, 4'd0, 64'd100, 64'd7, 0, 0, 64'd14, 0, 1'b0, 64));
        vt.push_back(mk(4'd14, 4'd0, 64'd100, 64'd7, 0, 0, 64'd2, 0, 1'b0, 64));
        vt.push_back(mk(4'd0,  4'd6, 64'd1, '1, 64'h10, 64'h10, 64'd0, 64'h20, 1'b0, 1));
        vt.push_back(mk(4'd5,  4'd0, 64'd1, 64'd67, 0, 0, 64'd8, 0, 1'b0, 1));

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_pc = '0; in_imm = '0; in_alu_op = '0; in_br_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", word_t'(in_ready), '0);
        check("reset out_valid", word_t'(out_valid), '0);
        check("reset out_result", out_result, '0);
        check("reset out_target", out_target, '0);
        check("reset out_redirect", word_t'(out_redirect), '0);
        rst = 1'b0; #1;
        check("in_ready after reset", word_t'(in_ready), 64'd1);

        foreach (vt[i])
            run_cmp($sformatf("vec%0d", i), vt[i].alu, vt[i].br, vt[i].a, vt[i].b, vt[i].pc, vt[i].imm, vt[i].e);

        // back-to-back adds, one per cycle
        out_ready = 1'b1; in_valid = 1'b1; in_alu_op = 4'd0; in_br_sel = 4'd0;
        for (int i = 0; i < 4; i++) begin
            in_a = word_t'(i * 3 + 1); in_b = 64'd1000;
            check($sformatf("b2b%0d in_ready", i), word_t'(in_ready), 64'd1);
            @(posedge clk); #1;
            check($sformatf("b2b%0d out_valid", i), word_t'(out_valid), 64'd1);
            check($sformatf("b2b%0d result", i), out_result, word_t'(i * 3 + 1001));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b drain out_valid", word_t'(out_valid), '0);

        // backpressure: result held 5 cycles while a new op is offered
        out_ready = 1'b0; in_valid = 1'b1; in_a = 64'd100; in_b = 64'd23;
        @(posedge clk); #1;
        in_a = 64'd1; in_b = 64'd1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d out_valid", i), word_t'(out_valid), 64'd1);
            check($sformatf("bp%0d result", i), out_result, 64'd123);
            check($sformatf("bp%0d in_ready", i), word_t'(in_ready), '0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; #1;
        check("bp release in_ready", word_t'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next result", out_result, 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp idle out_valid", word_t'(out_valid), '0);

        // flush in the middle of a divide
        in_alu_op = 4'd11; in_a = 64'd1000; in_b = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; #1;
        check("flush cycle in_ready", word_t'(in_ready), '0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; #1;
        check("post-flush in_ready", word_t'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flushed div out_valid", word_t'(seen), '0);

        // reset in the middle of a divide after a JAL left non-zero outputs
        run_cmp("jal pre-reset", 4'd0, 4'd7, 0, 0, 64'h2000, 64'h40,
                model(4'd0, 4'd7, 0, 0, 64'h2000, 64'h40));
        in_alu_op = 4'd12; in_br_sel = 4'd0; in_a = 64'd77; in_b = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-div rst out_valid", word_t'(out_valid), '0);
        check("mid-div rst result", out_result, '0);
        check("mid-div rst target", out_target, '0);
        check("mid-div rst redirect", word_t'(out_redirect), '0);
        check("mid-div rst in_ready", word_t'(in_ready), '0);
        rst = 1'b0; #1;
        check("post-rst in_ready", word_t'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("post-rst no pulse", word_t'(seen), '0);

        // randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ralu = 4'($urandom_range(0, 15));
            rbr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = MIN; rb = '1; end
            else if (sel == 2) begin ra = word_t'($urandom_range(0, 500)); rb = word_t'($urandom_range(1, 9)); end
            else if (sel == 3) rb = word_t'(ra == rb);
            e = model(ralu, rbr, ra, rb, {$urandom, $urandom} & ~64'd3, {$urandom, $urandom});
            in_pc = '0;
            run_cmp($sformatf("rnd%0d op%0d br%0d", i, ralu, rbr), ralu, rbr, ra, rb,
                    64'h8000_1000 + word_t'(i * 16), word_t'(i) - 64'd20,
                    model(ralu, rbr, ra, rb, 64'h8000_1000 + word_t'(i * 16), word_t'(i) - 64'd20));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
